// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch-to-decode instruction queue.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents: fetch_entry_t (one buffered word), INSTR_LEN_32 (low-bit pattern
// of a 32-bit RISC-V encoding) and is_illegal(), which flags non-32-bit encodings.
package fetch_pkg;

    // Datapath width of PC and instruction fields.
    localparam int FQ_BITS = 32;

    // instr[1:0] of every 32-bit RV instruction.
    localparam logic [1:0] INSTR_LEN_32 = 2'b11;

    typedef struct packed {
        logic [FQ_BITS-1:0] pc;
        logic [FQ_BITS-1:0] instr;
        logic               illegal;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic is_illegal(input logic [FQ_BITS-1:0] instr);
        return (instr[1:0] != INSTR_LEN_32);
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: DEPTH x fetch_entry_t register file.
// Latency: write visible after the clock edge; read is combinational.
// Backpressure: none, the caller gates i_we.
//
// Ports: clk, reset_n (async, active-low, clears every entry),
//        i_we / i_waddr / i_wdata write port, i_raddr / o_rdata read port.
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_we,
    input  logic [PTR_W-1:0]   i_waddr,
    input  logic [ENTRY_W-1:0] i_wdata,
    input  logic [PTR_W-1:0]   i_raddr,
    output logic [ENTRY_W-1:0] o_rdata
);

    fetch_entry_t r_mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= fetch_entry_t'(i_wdata);
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order instruction buffer between fetch and decode; flushes on redirect.
// Latency: 1 cycle push-to-head (0 cycles via bypass when FETCH_QUEUE_BYPASS_EN is defined).
// Backpressure: in_ready drops only when full, independent of out_ready; out_ready ignored when empty.
//
// Ports: clk, reset_n (async, active-low), flush (drop everything, beats push/pop),
//        in_valid/in_ready/in_pc/in_instr (from fetch),
//        out_valid/out_ready/out_pc/out_instr/out_illegal (to decode), count (occupancy).
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (empty-queue combinational bypass).
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int bits  = FQ_BITS,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [bits-1:0]          in_pc,
    input  logic [bits-1:0]          in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [bits-1:0]          out_pc,
    output logic [bits-1:0]          out_instr,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    fetch_entry_t     w_wr_entry;
    logic [ENTRY_W-1:0] w_rd_raw;
    fetch_entry_t     w_rd_entry;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass;

    assign w_empty          = (r_count == '0);
    assign w_wr_entry.pc    = in_pc;
    assign w_wr_entry.instr = in_instr;
    assign w_wr_entry.illegal = is_illegal(in_instr);
    assign w_rd_entry       = fetch_entry_t'(w_rd_raw);

    // in_ready looks only at occupancy so a full queue never accepts, even
    // when decode drains the head in the same cycle.
    assign in_ready = (r_count != FULL_CNT);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: hand the incoming word straight to decode. If decode takes
    // it this cycle it is never written; otherwise it is stored as usual.
    assign w_bypass    = w_empty && in_valid && !flush;
    assign out_valid   = !w_empty || w_bypass;
    assign out_pc      = w_bypass ? in_pc    : w_rd_entry.pc;
    assign out_instr   = w_bypass ? in_instr : w_rd_entry.instr;
    assign out_illegal = w_bypass ? w_wr_entry.illegal : w_rd_entry.illegal;
    assign w_push      = in_valid && in_ready && !flush && !(w_bypass && out_ready);
    // A bypass consume leaves storage untouched, so it is not a pop.
    assign w_pop       = !w_empty && out_ready && !flush;
`else
    assign w_bypass    = 1'b0;
    assign out_valid   = !w_empty;
    assign out_pc      = w_rd_entry.pc;
    assign out_instr   = w_rd_entry.instr;
    assign out_illegal = w_rd_entry.illegal;
    assign w_push      = in_valid && in_ready && !flush;
    assign w_pop       = out_valid && out_ready && !flush;
`endif

    assign count = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_raw)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed steps with a scoreboard of
// expected head entries, plus explicit checks at the boundary conditions.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int BITS  = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] in_pc;
    logic [BITS-1:0] in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_pc;
    logic [BITS-1:0] out_instr;
    logic            out_illegal;
    logic [2:0]      count;

    typedef struct {
        logic [BITS-1:0] pc;
        logic [BITS-1:0] instr;
        logic            ill;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fetch_queue #(.bits(BITS), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_illegal (out_illegal),
        .count       (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the
    // model by what the edge should do. Returns #1 after the edge.
    task automatic tick();
        int   n;
        logic byp;
        logic ev;
        logic do_pop;
        logic do_push;
        exp_t head;
        exp_t inw;
        #1;
        n   = sb.size();
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (n == 0) && in_valid && !flush;
`endif
        inw.pc    = in_pc;
        inw.instr = in_instr;
        inw.ill   = (in_instr[1:0] != 2'b11);
        ev = (n != 0) || byp;
        chk("out_valid", out_valid, ev);
        chk("in_ready", in_ready, n != DEPTH);
        chk("count", count, n);
        if (ev) begin
            head = byp ? inw : sb[0];
            chk("out_pc", out_pc, head.pc);
            chk("out_instr", out_instr, head.instr);
            chk("out_illegal", out_illegal, head.ill);
        end
        do_pop  = ev && out_ready && !flush;
        do_push = in_valid && (n != DEPTH) && !flush && !(byp && out_ready);
        @(posedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            if (do_pop && !byp) void'(sb.pop_front());
            if (do_push) sb.push_back(inw);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [BITS-1:0] pc, input logic [BITS-1:0] ins);
        in_valid = v;
        in_pc    = pc;
        in_instr = ins;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0);

        // Reset state
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", count, 0);
        #9 reset_n = 1'b1;

        // Three pushes held, then drained in order
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i * 4), 32'h13);
            tick();
        end
        drive(1'b0, '0, '0);
        chk("t1_count3", count, 3);
        chk("t1_head_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("t1_empty", out_valid, 0);
        tick();

        // Fill to DEPTH, reject the 5th, one pop reopens
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4), 32'h13);
            tick();
        end
        chk("t2_full_ready", in_ready, 0);
        chk("t2_full_count", count, 4);
        drive(1'b1, 32'h110, 32'h13);
        tick();
        chk("t2_5th_count", count, 4);
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t2_reopen_ready", in_ready, 1);
        chk("t2_reopen_count", count, 3);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Steady streaming from half-full, pointers wrap several times
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), 32'h13);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 2; i < 18; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), 32'h13 | (32'(i) << 7));
            tick();
        end
        drive(1'b0, '0, '0);
        chk("t3_steady_count", count, 2);
        for (int i = 0; i < 3; i++) tick();

        // Flush with a push in the same cycle
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(i * 4), 32'h13);
            tick();
        end
        flush = 1'b1;
        drive(1'b1, 32'h999, 32'h13);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        chk("t4_flush_count", count, 0);
        chk("t4_flush_valid", out_valid, 0);
        drive(1'b1, 32'h400, 32'h33);
        tick();
        drive(1'b0, '0, '0);
        chk("t4_after_pc", out_pc, 32'h400);
        out_ready = 1'b1;
        tick();
        tick();

        // Illegal encoding flag
        out_ready = 1'b0;
        drive(1'b1, 32'h500, 32'h1);
        tick();
        drive(1'b1, 32'h504, 32'h13);
        tick();
        drive(1'b0, '0, '0);
        chk("t5_illegal1", out_illegal, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5_illegal0", out_illegal, 0);
        chk("t5_pc", out_pc, 32'h504);
        out_ready = 1'b1;
        tick();
        tick();

        // Asynchronous reset between edges
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h600 + 32'(i * 4), 32'h13);
            tick();
        end
        drive(1'b0, '0, '0);
        chk("t6_pre_count", count, 2);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_count", count, 0);
        chk("t6_async_pc", out_pc, 0);
        sb.delete();
        #2 reset_n = 1'b1;

        // Push into an empty queue with decode ready
        out_ready = 1'b1;
        drive(1'b1, 32'h700, 32'h13);
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("t7_byp_valid", out_valid, 1);
        chk("t7_byp_pc", out_pc, 32'h700);
`else
        chk("t7_nobyp_valid", out_valid, 0);
`endif
        tick();
        drive(1'b0, '0, '0);
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("t7_byp_count", count, 0);
`else
        chk("t7_nobyp_count", count, 1);
        chk("t7_nobyp_pc", out_pc, 32'h700);
`endif
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage and decode. Captures each instruction word returned by fetch, with the PC it was fetched from, into a small in-order FIFO and presents them to decode over a valid/ready handshake. It decouples memory latency from decode stalls, and drops all buffered words on a control-flow redirect.

## Interface
- bits, 32: data and address width.
- DEPTH, 4: number of entries. Must be a power of two and at least 2.
- clk  in  1: single clock, rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- flush  in  1: discard all entries; from branch/jump redirect.
- in_valid  in  1: fetch presents a word.
- in_ready  out  1: queue accepts the word.
- in_pc  in  bits: PC of the presented word.
- in_instr  in  bits: instruction word.
- out_valid  out  1: head entry is valid for decode.
- out_ready  in  1: decode consumes the head.
- out_pc  out  bits: PC of the head entry.
- out_instr  out  bits: instruction of the head entry.
- out_illegal  out  1: head word has instr[1:0] != 2'b11 (not a 32-bit RV encoding).
- count  out  $clog2(DEPTH)+1: current occupancy.

## Operation
- Circular buffer with write pointer wr_ptr, read pointer rd_ptr (each $clog2(DEPTH) bits, wrap modulo DEPTH), and occupancy counter count.
- Push when in_valid && in_ready && !flush. Writes {in_pc, in_instr, illegal} at wr_ptr, then increments wr_ptr.
- Pop when out_valid && out_ready && !flush. Increments rd_ptr.
- illegal = (in_instr[1:0] != 2'b11). It is computed at push and stored with the entry.
- in_ready = (count != DEPTH). It does not depend on out_ready, so there is no push into a full queue even when a pop occurs in the same cycle.
- out_valid = (count != 0). out_pc, out_instr and out_illegal come from the entry at rd_ptr.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- flush has priority over push and pop. On the next edge wr_ptr = rd_ptr = count = 0. A push or pop presented in the flush cycle has no effect.
- Reset (reset_n low, asynchronous):
  - pointers = 0, count = 0, all storage = 0.
  - Outputs therefore reset to out_valid=0, out_pc=0, out_instr=0, out_illegal=0, in_ready=1, count=0.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.

## Timing
- Without bypass: a word pushed at edge N is visible on out_* from edge N (i.e. during cycle N+1). Minimum latency is 1 cycle.
- All outputs are purely functions of registered state. No combinational path from in_* or out_ready to any output.
- Sustained throughput is 1 word/cycle whenever the queue is neither empty nor full.
- Full (count == DEPTH): in_ready=0. A pop that cycle makes in_ready=1 in the following cycle.
- Empty (count == 0): out_valid=0 and out_ready is ignored.

## Configuration
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count == 0 and in_valid && !flush, out_valid=1 in the same cycle, and out_pc/out_instr/out_illegal are driven combinationally from in_*.
  - If out_ready is also 1, the word is consumed without being written and count stays 0.
  - If out_ready is 0, the word is written normally.
- Undefined: no combinational input-to-output path; the behaviour in Timing applies unchanged.

## Structure
- fetch_pkg holds:
  - typedef fetch_entry_t: packed struct {pc, instr, illegal}.
  - localparam INSTR_LEN_32 = 2'b11.
  - Helper function is_illegal(instr).
- Sub-module fetch_queue_mem:
  - DEPTH x fetch_entry_t storage, 1 write port, 1 asynchronous read port, asynchronous reset to 0.
  - The top level holds pointers, counter and handshake logic.

## Test plan
- Reset, then 3 pushes (PC 0x00/0x04/0x08, instr 0x00000013) with out_ready=0 -> count=3, out_pc=0x00; then out_ready=1 for 3 cycles -> out_pc 0x00, 0x04, 0x08 in order, then out_valid=0.
- Push DEPTH=4 words with out_ready=0 -> in_ready=0 at count=4; a 5th in_valid is not accepted; one pop -> in_ready=1 the next cycle, count=3.
- Continuous in_valid and out_ready for 16 cycles from half-full (count=2) -> count stays 2, PCs come out in order, pointers wrap correctly.
- flush asserted with count=3 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, the flush-cycle word is absent.
- Push instr 0x00000001 -> out_illegal=1 at head; push 0x00000013 -> out_illegal=0.
- reset_n dropped between edges at count=2 -> out_valid=0 and count=0 immediately. With FETCH_QUEUE_BYPASS_EN: push to empty queue with out_ready=1 -> out_valid=1 the same cycle, count remains 0.
